// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/flush bundle between the ID/WB stages and the register scoreboard.
// The master side drives the stage inputs; the slave side (the scoreboard) returns stall and status.
interface reg_scoreboard_if;
  logic        flush_i;
  logic        issue_valid_i;
  logic [4:0]  issue_rs_i;
  logic [4:0]  issue_rt_i;
  logic        issue_use_rs_i;
  logic        issue_use_rt_i;
  logic        issue_we_i;
  logic [4:0]  issue_rd_i;
  logic        wb_we_i;
  logic [4:0]  wb_rd_i;
  logic        issue_stall_o;
  logic [31:0] busy_vec_o;
  logic [6:0]  inflight_o;
  logic        err_o;

  modport master (
    output flush_i, issue_valid_i, issue_rs_i, issue_rt_i, issue_use_rs_i,
           issue_use_rt_i, issue_we_i, issue_rd_i, wb_we_i, wb_rd_i,
    input  issue_stall_o, busy_vec_o, inflight_o, err_o
  );

  modport slave (
    input  flush_i, issue_valid_i, issue_rs_i, issue_rt_i, issue_use_rs_i,
           issue_use_rt_i, issue_we_i, issue_rd_i, wb_we_i, wb_rd_i,
    output issue_stall_o, busy_vec_o, inflight_o, err_o
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-GPR pending-write counters between issue and writeback; stalls issue on RAW hazards
// and on counter saturation. $0 is never tracked.
module reg_scoreboard #(
  parameter int CNT_W     = 2,
  parameter int BYPASS_WB = 1
) (
  input logic             clk_i,
  input logic             rst_i,
  reg_scoreboard_if.slave sb
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [0:31];
  logic [CNT_W-1:0] cnt_d [0:31];
  logic [6:0]       inflight_q, inflight_d;
  logic             err_q, err_d;

  logic [31:0] pend_vec;
  logic [31:0] busy_vec;
  logic        full_rd;
  logic        stall;
  logic        accept;
  logic        inc_any;
  logic        dec_any;
  logic        err_hit;

  // A source whose last pending write retires this cycle is served by the WB forwarding path.
  always_comb begin
    pend_vec = '0;
    busy_vec = '0;
    for (int r = 1; r < 32; r++) begin
      busy_vec[r] = (cnt_q[r] != '0);
      pend_vec[r] = (cnt_q[r] != '0) &&
                    !((BYPASS_WB != 0) && sb.wb_we_i && (sb.wb_rd_i == 5'(r)) &&
                      (cnt_q[r] == CNT_ONE));
    end
  end

  always_comb begin
    full_rd = sb.issue_we_i && (sb.issue_rd_i != 5'd0) &&
              (cnt_q[sb.issue_rd_i] == CNT_MAX) &&
              !(sb.wb_we_i && (sb.wb_rd_i == sb.issue_rd_i));
    stall   = sb.issue_valid_i &&
              ((sb.issue_use_rs_i && pend_vec[sb.issue_rs_i]) ||
               (sb.issue_use_rt_i && pend_vec[sb.issue_rt_i]) ||
               full_rd);
    accept  = sb.issue_valid_i && !stall && !sb.flush_i;
    inc_any = accept && sb.issue_we_i && (sb.issue_rd_i != 5'd0);
    dec_any = sb.wb_we_i && (sb.wb_rd_i != 5'd0) && (cnt_q[sb.wb_rd_i] != '0);
    // Retiring an idle register is an error unless an issue to it lands in the same cycle.
    err_hit = sb.wb_we_i && (sb.wb_rd_i != 5'd0) && (cnt_q[sb.wb_rd_i] == '0) &&
              !(inc_any && (sb.issue_rd_i == sb.wb_rd_i)) && !sb.flush_i;
  end

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (sb.flush_i) begin
        cnt_d[r] = '0;
      end else if (inc_any && (sb.issue_rd_i == 5'(r)) &&
                   !(dec_any && (sb.wb_rd_i == 5'(r)))) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec_any && (sb.wb_rd_i == 5'(r)) &&
                   !(inc_any && (sb.issue_rd_i == 5'(r)))) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
    if (sb.flush_i) begin
      inflight_d = '0;
    end else begin
      inflight_d = inflight_q + 7'(inc_any) - 7'(dec_any);
    end
    err_d = err_q || err_hit;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign sb.issue_stall_o = stall;
  assign sb.busy_vec_o    = busy_vec;
  assign sb.inflight_o    = inflight_q;
  assign sb.err_o         = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed hazard scenarios plus random traffic,
// checked against an integer-count reference model.
module tb_reg_scoreboard;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  reg_scoreboard_if sb_if ();

  reg_scoreboard #(.CNT_W(2), .BYPASS_WB(1)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .sb    (sb_if)
  );

  // Reference model: plain pending-write counts per register.
  int  mcnt [32];
  bit  merr;

  logic [0:0]  exp_stall_q [$];
  logic [39:0] exp_q       [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] model_state();
    logic [31:0] busy;
    int          sum;
    busy = '0;
    sum  = 0;
    for (int r = 1; r < 32; r++) begin
      busy[r] = (mcnt[r] > 0);
      sum += mcnt[r];
    end
    return {busy, 7'(sum), merr};
  endfunction

  function automatic bit model_pend(input int s, input bit wwe, input int wrd);
    if (s == 0 || mcnt[s] == 0) return 1'b0;
    if (wwe && wrd == s && mcnt[s] == 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    merr = 1'b0;
  endtask

  task automatic idle();
    sb_if.flush_i        = 1'b0;
    sb_if.issue_valid_i  = 1'b0;
    sb_if.issue_rs_i     = '0;
    sb_if.issue_rt_i     = '0;
    sb_if.issue_use_rs_i = 1'b0;
    sb_if.issue_use_rt_i = 1'b0;
    sb_if.issue_we_i     = 1'b0;
    sb_if.issue_rd_i     = '0;
    sb_if.wb_we_i        = 1'b0;
    sb_if.wb_rd_i        = '0;
  endtask

  // Called just after a posedge; drives one cycle and returns just after the next posedge.
  task automatic step(input bit v, input bit [4:0] rs, input bit [4:0] rt,
                      input bit urs, input bit urt, input bit we, input bit [4:0] rd,
                      input bit wwe, input bit [4:0] wrd, input bit fl);
    bit stall;
    bit inc;
    int orig;
    sb_if.issue_valid_i  = v;
    sb_if.issue_rs_i     = rs;
    sb_if.issue_rt_i     = rt;
    sb_if.issue_use_rs_i = urs;
    sb_if.issue_use_rt_i = urt;
    sb_if.issue_we_i     = we;
    sb_if.issue_rd_i     = rd;
    sb_if.wb_we_i        = wwe;
    sb_if.wb_rd_i        = wrd;
    sb_if.flush_i        = fl;
    stall = v && ((urs && model_pend(int'(rs), wwe, int'(wrd))) ||
                  (urt && model_pend(int'(rt), wwe, int'(wrd))) ||
                  (we && rd != 0 && mcnt[rd] == 3 && !(wwe && wrd == rd)));
    exp_stall_q.push_back(stall);
    if (fl) begin
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
    end else begin
      orig = mcnt[wrd];
      inc  = v && !stall && we && rd != 0;
      if (inc) mcnt[rd]++;
      if (wwe && wrd != 0) begin
        if (orig > 0) mcnt[wrd]--;
        else if (!(inc && rd == wrd)) merr = 1'b1;
      end
    end
    @(posedge clk);
    exp_q.push_back(model_state());
    #1;
  endtask

  // Monitors: stall is sampled mid-cycle, registered status shortly after each edge.
  always @(negedge clk) begin
    if (exp_stall_q.size() > 0) begin
      logic [0:0] e;
      e = exp_stall_q.pop_front();
      check("issue_stall", 64'(sb_if.issue_stall_o), 64'(e));
    end
  end

  always @(posedge clk) begin
    #3;
    if (exp_q.size() > 0) begin
      logic [39:0] e;
      e = exp_q.pop_front();
      check("busy_vec", 64'(sb_if.busy_vec_o), 64'(e[39:8]));
      check("inflight", 64'(sb_if.inflight_o), 64'(e[7:1]));
      check("err",      64'(sb_if.err_o),      64'(e[0]));
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    idle();
    model_reset();
    #2;
    check("reset_busy",     64'(sb_if.busy_vec_o),    64'd0);
    check("reset_inflight", 64'(sb_if.inflight_o),    64'd0);
    check("reset_err",      64'(sb_if.err_o),         64'd0);
    check("reset_stall",    64'(sb_if.issue_stall_o), 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // RAW hazard, then cleared by a same-cycle WB of the last pending write
    step(1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    step(1, 8, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 8, 0, 1, 0, 0, 0, 1, 8, 0);

    // Saturation on rd=4, then drain
    repeat (3) step(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 4, 1, 4, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 4, 0);

    // $0 is invisible
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 1, 0, 1, 0, 0);

    // Retire of an idle register is a sticky error that survives flush
    step(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Flush with five pending writes overrides a same-cycle accepted issue
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 10, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 7, 0, 0, 1);

    // Asynchronous reset between edges with cnt[5]=2 and err set
    step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    idle();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_busy",     64'(sb_if.busy_vec_o), 64'd0);
    check("async_rst_inflight", 64'(sb_if.inflight_o), 64'd0);
    check("async_rst_err",      64'(sb_if.err_o),      64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic concentrated on a few registers so hazards are frequent
    for (int n = 0; n < 400; n++) begin
      bit [4:0] wrd;
      int       start;
      wrd   = 5'($urandom_range(0, 7));
      start = $urandom_range(1, 31);
      if ($urandom_range(0, 7) != 0) begin
        for (int k = 0; k < 31; k++) begin
          int r;
          r = ((start + k - 1) % 31) + 1;
          if (mcnt[r] > 0) begin
            wrd = 5'(r);
            break;
          end
        end
      end
      step($urandom_range(0, 3) != 0,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 2) != 0, wrd,
           $urandom_range(0, 29) == 0);
    end

    idle();
    repeat (2) @(posedge clk);
    #4;
    check("queues_drained", 64'(exp_q.size() + exp_stall_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
